// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - shared graphics types: setup status codes, Q16.16 constant, setup record
package graphics_pkg;

    localparam int GFX_COORD_WIDTH = 32;
    localparam logic signed [GFX_COORD_WIDTH-1:0] ONE = 32'sh0001_0000;

    typedef enum logic [1:0] {
        EMITTED    = 2'b00,
        DEGENERATE = 2'b01,
        BACKFACE   = 2'b10,
        OFFSCREEN  = 2'b11
    } tri_status_t;

    // Record layout seen by the rasterizer at the default coordinate width
    typedef struct packed {
        logic [2:0][GFX_COORD_WIDTH-1:0]       edge_a;
        logic [2:0][GFX_COORD_WIDTH-1:0]       edge_b;
        logic [2:0][GFX_COORD_WIDTH+1:0]       edge_c;
        logic signed [GFX_COORD_WIDTH+1:0]     area2;
        logic [GFX_COORD_WIDTH/2-1:0]          bbox_min_x;
        logic [GFX_COORD_WIDTH/2-1:0]          bbox_max_x;
        logic [GFX_COORD_WIDTH/2-1:0]          bbox_min_y;
        logic [GFX_COORD_WIDTH/2-1:0]          bbox_max_y;
        logic [2:0][GFX_COORD_WIDTH-1:0]       vert_z;
    } setup_rec_t;

endpackage

// File: rtl/tri_edge_coeff.sv
// rtl/tri_edge_coeff.sv - combinational edge-function coefficients A, B, C for edge va->vb
module tri_edge_coeff
#(
    parameter int COORD_WIDTH = 32
)
(
    input  logic signed [COORD_WIDTH/2-1:0] xa,
    input  logic signed [COORD_WIDTH/2-1:0] ya,
    input  logic signed [COORD_WIDTH/2-1:0] xb,
    input  logic signed [COORD_WIDTH/2-1:0] yb,
    output logic signed [COORD_WIDTH-1:0]   a,
    output logic signed [COORD_WIDTH-1:0]   b,
    output logic signed [COORD_WIDTH+1:0]   c
);

    logic signed [COORD_WIDTH+1:0] xa_w, ya_w, xb_w, yb_w;

    assign xa_w = (COORD_WIDTH+2)'(xa);
    assign ya_w = (COORD_WIDTH+2)'(ya);
    assign xb_w = (COORD_WIDTH+2)'(xb);
    assign yb_w = (COORD_WIDTH+2)'(yb);

    assign a = COORD_WIDTH'(ya) - COORD_WIDTH'(yb);
    assign b = COORD_WIDTH'(xb) - COORD_WIDTH'(xa);
    assign c = xa_w * yb_w - xb_w * ya_w;

endmodule

// File: rtl/triangle_setup.sv
// rtl/triangle_setup.sv - triangle setup: edge coefficients, area, bbox, culling
// TRIANGLE_SETUP_BACKFACE_CULL_EN: cull negative-area triangles instead of flipping them.
module triangle_setup
    import graphics_pkg::*;
#(
    parameter int COORD_WIDTH = 32,
    parameter int FB_WIDTH    = 320,
    parameter int FB_HEIGHT   = 180
)
(
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             tri_valid,
    output logic                             tri_ready,
    input  logic [2:0][2:0][COORD_WIDTH-1:0] tri_verts,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [2:0][COORD_WIDTH-1:0]      edge_a,
    output logic [2:0][COORD_WIDTH-1:0]      edge_b,
    output logic [2:0][COORD_WIDTH+1:0]      edge_c,
    output logic signed [COORD_WIDTH+1:0]    area2,
    output logic [COORD_WIDTH/2-1:0]         bbox_min_x,
    output logic [COORD_WIDTH/2-1:0]         bbox_max_x,
    output logic [COORD_WIDTH/2-1:0]         bbox_min_y,
    output logic [COORD_WIDTH/2-1:0]         bbox_max_y,
    output logic [2:0][COORD_WIDTH-1:0]      vert_z,
    output logic                             busy,
    output logic                             done,
    output logic [1:0]                       status
);

    localparam int H = COORD_WIDTH / 2;
    localparam logic signed [H-1:0] X_LAST = H'(FB_WIDTH - 1);
    localparam logic signed [H-1:0] Y_LAST = H'(FB_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EDGE0, S_EDGE1, S_EDGE2, S_AREA, S_DECIDE, S_OUTPUT
    } state_t;

    state_t state;

    logic [2:0][H-1:0] vx, vy;
    logic [1:0] ia, ib;
    logic signed [COORD_WIDTH-1:0] coef_a, coef_b;
    logic signed [COORD_WIDTH+1:0] coef_c;
    logic signed [H-1:0] min_x, max_x, min_y, max_y;
    logic offscreen, cull;
    tri_status_t cull_status;

    // Only the integer part of x/y feeds setup; fractions are deliberately dropped
    logic unused_frac;
    always_comb begin
        unused_frac = 1'b0;
        for (int i = 0; i < 3; i++)
            unused_frac = unused_frac ^ (^tri_verts[i][0][H-1:0]) ^ (^tri_verts[i][1][H-1:0]);
    end

    always_comb begin
        case (state)
            S_EDGE1: begin ia = 2'd1; ib = 2'd2; end
            S_EDGE2: begin ia = 2'd2; ib = 2'd0; end
            default: begin ia = 2'd0; ib = 2'd1; end
        endcase
    end

    tri_edge_coeff #(.COORD_WIDTH(COORD_WIDTH)) u_edge_coeff (
        .xa (vx[ia]),
        .ya (vy[ia]),
        .xb (vx[ib]),
        .yb (vy[ib]),
        .a  (coef_a),
        .b  (coef_b),
        .c  (coef_c)
    );

    always_comb begin
        min_x = $signed(vx[0]);
        max_x = $signed(vx[0]);
        min_y = $signed(vy[0]);
        max_y = $signed(vy[0]);
        for (int i = 1; i < 3; i++) begin
            if ($signed(vx[i]) < min_x) min_x = $signed(vx[i]);
            if ($signed(vx[i]) > max_x) max_x = $signed(vx[i]);
            if ($signed(vy[i]) < min_y) min_y = $signed(vy[i]);
            if ($signed(vy[i]) > max_y) max_y = $signed(vy[i]);
        end
        offscreen = max_x[H-1] || max_y[H-1] || (min_x > X_LAST) || (min_y > Y_LAST);
    end

    always_comb begin
        cull        = 1'b1;
        cull_status = DEGENERATE;
        if (area2 == '0)
            cull_status = DEGENERATE;
`ifdef TRIANGLE_SETUP_BACKFACE_CULL_EN
        else if (area2[COORD_WIDTH+1])
            cull_status = BACKFACE;
`endif
        else if (offscreen)
            cull_status = OFFSCREEN;
        else
            cull = 1'b0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            tri_ready  <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            status     <= EMITTED;
            vx         <= '0;
            vy         <= '0;
            vert_z     <= '0;
            edge_a     <= '0;
            edge_b     <= '0;
            edge_c     <= '0;
            area2      <= '0;
            bbox_min_x <= '0;
            bbox_max_x <= '0;
            bbox_min_y <= '0;
            bbox_max_y <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tri_valid) begin
                        for (int i = 0; i < 3; i++) begin
                            vx[i]     <= tri_verts[i][0][COORD_WIDTH-1:H];
                            vy[i]     <= tri_verts[i][1][COORD_WIDTH-1:H];
                            vert_z[i] <= tri_verts[i][2];
                        end
                        tri_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_EDGE0;
                    end
                end
                S_EDGE0, S_EDGE1, S_EDGE2: begin
                    edge_a[ia] <= coef_a;
                    edge_b[ia] <= coef_b;
                    edge_c[ia] <= coef_c;
                    state <= (state == S_EDGE0) ? S_EDGE1 :
                             (state == S_EDGE1) ? S_EDGE2 : S_AREA;
                end
                S_AREA: begin
                    area2 <= $signed(edge_c[0]) + $signed(edge_c[1]) + $signed(edge_c[2]);
                    state <= S_DECIDE;
                end
                S_DECIDE: begin
                    if (cull) begin
                        done      <= 1'b1;
                        status    <= cull_status;
                        tri_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
`ifndef TRIANGLE_SETUP_BACKFACE_CULL_EN
                        // Clockwise input: reverse orientation so inside tests stay E >= 0
                        if (area2[COORD_WIDTH+1]) begin
                            for (int i = 0; i < 3; i++) begin
                                edge_a[i] <= -edge_a[i];
                                edge_b[i] <= -edge_b[i];
                                edge_c[i] <= -edge_c[i];
                            end
                            area2 <= -area2;
                        end
`endif
                        bbox_min_x <= min_x[H-1] ? '0 : min_x;
                        bbox_min_y <= min_y[H-1] ? '0 : min_y;
                        bbox_max_x <= (max_x > X_LAST) ? X_LAST : max_x;
                        bbox_max_y <= (max_y > Y_LAST) ? Y_LAST : max_y;
                        out_valid  <= 1'b1;
                        state      <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        status    <= EMITTED;
                        tri_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_setup.sv
// tb/tb_triangle_setup.sv - directed self-checking bench for triangle_setup
module tb_triangle_setup;
    import graphics_pkg::*;

    typedef logic [2:0][2:0][31:0] verts_t;

    logic clk_in = 1'b0;
    logic rst_in, tri_valid, tri_ready, out_valid, out_ready, busy, done;
    verts_t tri_verts;
    logic [2:0][31:0] edge_a, edge_b, vert_z;
    logic [2:0][33:0] edge_c;
    logic signed [33:0] area2;
    logic [15:0] bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y;
    logic [1:0] status;

    int total = 0;
    int bad = 0;

    always #5 clk_in = ~clk_in;

    triangle_setup #(.COORD_WIDTH(32), .FB_WIDTH(320), .FB_HEIGHT(180)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_verts(tri_verts), .out_valid(out_valid), .out_ready(out_ready),
        .edge_a(edge_a), .edge_b(edge_b), .edge_c(edge_c), .area2(area2),
        .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
        .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y),
        .vert_z(vert_z), .busy(busy), .done(done), .status(status)
    );

    // Fractional parts are non-zero so that floor behaviour is exercised
    function automatic verts_t mk(input int x0, input int y0, input int x1, input int y1,
                                  input int x2, input int y2);
        verts_t v;
        int xs[3];
        int ys[3];
        xs = '{x0, x1, x2};
        ys = '{y0, y1, y2};
        for (int i = 0; i < 3; i++) begin
            v[i][0] = 32'(xs[i] * ONE + 32'h4000);
            v[i][1] = 32'(ys[i] * ONE + 32'h4000);
            v[i][2] = 32'((i + 1) * ONE + 32'h8000);
        end
        return v;
    endfunction

    // Returns at the negedge of T+1 (first cycle after the accepting edge)
    task automatic send_tri(input verts_t v);
        int n = 0;
        @(negedge clk_in);
        while (tri_ready !== 1'b1 && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        total++;
        if (tri_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready got=%0b exp=1", tri_ready);
        end
        tri_verts = v;
        tri_valid = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        tri_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (tri_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            status !== 2'b00 || area2 !== '0 || edge_c !== '0 || bbox_max_x !== '0) begin
            bad++;
            $display("FAIL reset_state got ready=%0b valid=%0b busy=%0b done=%0b status=%0d exp 1 0 0 0 0",
                     tri_ready, out_valid, busy, done, status);
        end
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic test_basic();
        int ea[3];
        int eb[3];
        longint ec[3];
        ea = '{0, -30, 30};
        eb = '{40, -40, 0};
        ec = '{-400, 1900, -300};
        out_ready = 1'b1;
        send_tri(mk(10, 10, 50, 10, 10, 40));
        total++;
        if (tri_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy got ready=%0b busy=%0b exp ready=0 busy=1", tri_ready, busy);
        end
        repeat (4) @(negedge clk_in);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early_valid got=%0b exp=0", out_valid);
        end
        @(negedge clk_in);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL basic_valid_t6 got=%0b exp=1", out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if ($signed(edge_a[i]) !== ea[i] || $signed(edge_b[i]) !== eb[i] || $signed(edge_c[i]) !== ec[i]) begin
                bad++;
                $display("FAIL basic_edge%0d got A=%0d B=%0d C=%0d exp A=%0d B=%0d C=%0d", i,
                         $signed(edge_a[i]), $signed(edge_b[i]), $signed(edge_c[i]), ea[i], eb[i], ec[i]);
            end
            total++;
            if (vert_z[i] !== 32'((i + 1) * ONE + 32'h8000)) begin
                bad++;
                $display("FAIL basic_z%0d got=%h exp=%h", i, vert_z[i], 32'((i + 1) * ONE + 32'h8000));
            end
        end
        total++;
        if (area2 !== 34'sd1200) begin
            bad++;
            $display("FAIL basic_area2 got=%0d exp=1200", area2);
        end
        total++;
        if (bbox_min_x !== 16'd10 || bbox_min_y !== 16'd10 || bbox_max_x !== 16'd50 || bbox_max_y !== 16'd40) begin
            bad++;
            $display("FAIL basic_bbox got=(%0d,%0d)-(%0d,%0d) exp=(10,10)-(50,40)",
                     bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y);
        end
        @(negedge clk_in);
        total++;
        if (done !== 1'b1 || status !== 2'b00 || out_valid !== 1'b0 || tri_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done got done=%0b status=%0d valid=%0b ready=%0b busy=%0b exp 1 0 0 1 0",
                     done, status, out_valid, tri_ready, busy);
        end
        @(negedge clk_in);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_pulse got=%0b exp=0", done);
        end
    endtask

    task automatic test_backface();
        out_ready = 1'b1;
        send_tri(mk(10, 10, 10, 40, 50, 10));
        repeat (5) @(negedge clk_in);
`ifdef TRIANGLE_SETUP_BACKFACE_CULL_EN
        total++;
        if (done !== 1'b1 || status !== 2'b10 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL backface_cull got done=%0b status=%0d valid=%0b exp 1 2 0", done, status, out_valid);
        end
`else
        begin
            int ea[3];
            int eb[3];
            longint ec[3];
            ea = '{30, -30, 0};
            eb = '{0, -40, 40};
            ec = '{-300, 1900, -400};
            total++;
            if (out_valid !== 1'b1 || area2 !== 34'sd1200) begin
                bad++;
                $display("FAIL flip_area2 got valid=%0b area2=%0d exp valid=1 area2=1200", out_valid, area2);
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if ($signed(edge_a[i]) !== ea[i] || $signed(edge_b[i]) !== eb[i] || $signed(edge_c[i]) !== ec[i]) begin
                    bad++;
                    $display("FAIL flip_edge%0d got A=%0d B=%0d C=%0d exp A=%0d B=%0d C=%0d", i,
                             $signed(edge_a[i]), $signed(edge_b[i]), $signed(edge_c[i]), ea[i], eb[i], ec[i]);
                end
            end
            @(negedge clk_in);
            total++;
            if (done !== 1'b1 || status !== 2'b00) begin
                bad++;
                $display("FAIL flip_done got done=%0b status=%0d exp 1 0", done, status);
            end
        end
`endif
    endtask

    task automatic test_degenerate();
        logic saw;
        out_ready = 1'b1;
        send_tri(mk(0, 0, 10, 10, 20, 20));
        saw = out_valid;
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk_in);
            saw = saw | out_valid;
            if (k == 5) begin
                total++;
                if (done !== 1'b0) begin
                    bad++;
                    $display("FAIL degen_early_done got=%0b exp=0", done);
                end
            end
            if (k == 6) begin
                total++;
                if (done !== 1'b1 || status !== 2'b01 || tri_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL degen_done got done=%0b status=%0d ready=%0b exp 1 1 1", done, status, tri_ready);
                end
            end
        end
        total++;
        if (saw !== 1'b0) begin
            bad++;
            $display("FAIL degen_no_valid got=%0b exp=0", saw);
        end
    endtask

    task automatic test_clamp();
        out_ready = 1'b1;
        send_tri(mk(-20, -5, 100, -5, -20, 300));
        repeat (5) @(negedge clk_in);
        total++;
        if (out_valid !== 1'b1 || area2 !== 34'sd36600) begin
            bad++;
            $display("FAIL clamp_area2 got valid=%0b area2=%0d exp valid=1 area2=36600", out_valid, area2);
        end
        total++;
        if (bbox_min_x !== 16'd0 || bbox_min_y !== 16'd0 || bbox_max_x !== 16'd100 || bbox_max_y !== 16'd179) begin
            bad++;
            $display("FAIL clamp_bbox got=(%0d,%0d)-(%0d,%0d) exp=(0,0)-(100,179)",
                     bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y);
        end
        total++;
        if ($signed(edge_a[0]) !== 0 || $signed(edge_b[0]) !== 120 || $signed(edge_c[0]) !== 64'sd600 ||
            $signed(edge_c[2]) !== 64'sd6100) begin
            bad++;
            $display("FAIL clamp_edges got A0=%0d B0=%0d C0=%0d C2=%0d exp 0 120 600 6100",
                     $signed(edge_a[0]), $signed(edge_b[0]), $signed(edge_c[0]), $signed(edge_c[2]));
        end
        @(negedge clk_in);
    endtask

    task automatic test_offscreen();
        out_ready = 1'b1;
        send_tri(mk(400, 10, 500, 10, 400, 60));
        repeat (5) @(negedge clk_in);
        total++;
        if (done !== 1'b1 || status !== 2'b11 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL offscreen got done=%0b status=%0d valid=%0b exp 1 3 0", done, status, out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_tri(mk(10, 10, 50, 10, 10, 40));
        repeat (4) @(negedge clk_in);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            total++;
            if (out_valid !== 1'b1 || area2 !== 34'sd1200 || $signed(edge_c[1]) !== 64'sd1900 ||
                bbox_max_x !== 16'd50 || tri_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || status !== 2'b11) begin
                bad++;
                $display("FAIL stall_cycle%0d got valid=%0b area2=%0d C1=%0d maxx=%0d ready=%0b busy=%0b done=%0b status=%0d exp 1 1200 1900 50 0 1 0 3",
                         k, out_valid, area2, $signed(edge_c[1]), bbox_max_x, tri_ready, busy, done, status);
            end
        end
        out_ready = 1'b1;
        @(negedge clk_in);
        total++;
        if (done !== 1'b1 || status !== 2'b00 || tri_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_release got done=%0b status=%0d ready=%0b valid=%0b exp 1 0 1 0",
                     done, status, tri_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send_tri(mk(10, 10, 50, 10, 10, 40));
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        total++;
        if (area2 !== '0 || edge_c[0] !== '0 || vert_z[0] !== '0 || bbox_max_x !== '0 ||
            out_valid !== 1'b0 || tri_ready !== 1'b1 || busy !== 1'b0 || status !== 2'b00) begin
            bad++;
            $display("FAIL async_reset got area2=%0d C0=%0d z0=%0d maxx=%0d valid=%0b ready=%0b busy=%0b exp zeros ready=1",
                     area2, $signed(edge_c[0]), vert_z[0], bbox_max_x, out_valid, tri_ready, busy);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        test_basic();
    endtask

    initial begin
        rst_in    = 1'b1;
        tri_valid = 1'b0;
        out_ready = 1'b0;
        tri_verts = '0;
        test_reset();
        test_basic();
        test_backface();
        test_degenerate();
        test_clamp();
        test_offscreen();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
